// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, NOP word, default reset PC.
package cpu_pkg;

  typedef enum logic {StRun = 1'b0, StHalt = 1'b1} fetch_state_e;

  localparam logic [31:0] NOP_INS          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: delivered instructions and stalled RUN cycles.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetched,
  input  logic        stalled,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (fetched) perf_fetched <= perf_fetched + 32'd1;
      if (stalled) perf_stall   <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a synchronous ROM, feeds IF/ID.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump_rst,
  input  logic [31:0]        jump_target,
  input  logic               halt,
  input  logic               go,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        Ins_o,
  output logic [31:0]        PC_o,
  output logic               valid_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  resp_pc_q;
  logic         resp_v_q;
  logic [31:0]  jump_pc;
  logic [31:0]  fetch_addr;
  logic         running;

  assign jump_pc    = word_align(jump_target);
  assign running    = (state_q == StRun);
  assign fetch_addr = jump_rst ? jump_pc : pc_q;

  // ROM controls are forced low during reset so every output reads 0.
  always_comb begin
    imem_en   = rst & (jump_rst | (running & ~halt & ~stall));
    imem_addr = rst ? IMEM_AW'(fetch_addr >> 2) : '0;
    valid_o   = resp_v_q & running & ~jump_rst;
    Ins_o     = valid_o ? imem_rdata : NOP_INS;
    PC_o      = valid_o ? resp_pc_q : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      resp_pc_q <= 32'h0;
      resp_v_q  <= 1'b0;
    end else if (jump_rst) begin
      pc_q      <= jump_pc + 32'd4;
      resp_pc_q <= jump_pc;
      resp_v_q  <= 1'b1;
    end else if (running) begin
      if (halt) begin
        // Rewind so the instruction displaced from IF/ID is refetched on resume.
        state_q  <= StHalt;
        pc_q     <= resp_pc_q;
        resp_v_q <= 1'b0;
      end else if (!stall) begin
        pc_q      <= pc_q + 32'd4;
        resp_pc_q <= pc_q;
        resp_v_q  <= 1'b1;
      end
    end else if (go && !halt) begin
      state_q <= StRun;
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .clk          (clk),
    .rst          (rst),
    .fetched      (valid_o & ~stall),
    .stalled      (stall & running),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage pipelined CPU and the producer side of the IF/ID pipeline register. It owns the PC and drives a synchronous instruction ROM. It presents each fetched instruction with its PC to IF/ID, and obeys the same stall, redirect (jump_rst) and halt controls that IF/ID receives, so that the two ends stay in lock-step.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- IMEM_AW, 10, instruction ROM word-address width
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hazard-unit hold; the same signal that drives IF/ID stall
- jump_rst  in  1  taken branch/jump redirect from EX; the same signal that flushes IF/ID
- jump_target  in  32  redirect byte address; bits [1:0] ignored, treated as 00
- halt  in  1  halt request from ID (program-exit syscall decoded)
- go  in  1  single-cycle resume pulse from the board "continue" key
- imem_en  out  1  ROM read enable; ROM output register holds its value while 0
- imem_addr  out  IMEM_AW  ROM word address, equal to fetch byte address [IMEM_AW+1:2]
- imem_rdata  in  32  ROM data for the address presented with imem_en=1 in the previous cycle
- Ins_o  out  32  instruction to IF/ID Ins_i
- PC_o  out  32  byte PC of Ins_o, to IF/ID PC_i
- valid_o  out  1  Ins_o/PC_o carry a real in-order instruction

## Operation
- Registers:
  - pc_q: next byte address to request.
  - resp_pc_q: PC of the data currently on imem_rdata.
  - resp_v_q: that data is meaningful.
  - state_q: RUN or HALT.
- Priority, highest first: rst, jump_rst, halt, stall, normal advance.
- jump_rst, in either state:
  - Drive imem_en=1 and imem_addr=jump_target.
  - pc_q <= target+4, resp_pc_q <= target, resp_v_q <= 1.
  - valid_o=0 in this cycle.
  - The state is unchanged, so a redirect while in HALT only retargets the PC.
- halt, in RUN without jump_rst:
  - state_q <= HALT.
  - pc_q <= resp_pc_q, so the instruction replaced in IF/ID is refetched on resume.
  - resp_v_q <= 0, imem_en=0.
- A halt that coincides with jump_rst is dropped, because EX is older than ID.
- HALT:
  - imem_en=0, valid_o=0; all registers except state are frozen.
  - go moves to RUN in the next cycle, with no fetch in the go cycle.
  - halt wins over go in the same cycle.
- stall, in RUN:
  - imem_en=0; pc_q, resp_pc_q and resp_v_q are held.
  - Ins_o/PC_o/valid_o therefore stay stable because the ROM holds its output.
- Advance, in RUN without stall:
  - imem_en=1, imem_addr=pc_q.
  - pc_q <= pc_q+4, with 32-bit wrap at 0xFFFF_FFFC -> 0.
  - resp_pc_q <= pc_q, resp_v_q <= 1.
- Outputs:
  - valid_o = resp_v_q & (state_q==RUN) & ~jump_rst.
  - Ins_o = valid_o ? imem_rdata : 32'h0 (NOP).
  - PC_o = valid_o ? resp_pc_q : 0.

## Timing
- Reset: pc_q=RESET_PC, resp_pc_q=0, resp_v_q=0, state_q=RUN.
- All outputs read 0 immediately on rst assertion, independent of clk.
- Fetch latency: an instruction is visible on Ins_o one cycle after its address is issued. After reset release, valid_o first rises in cycle 1.
- Redirect penalty is one bubble cycle; the target is on Ins_o in the cycle after jump_rst.
- Resume: go in cycle n, fetch in n+1, valid_o in n+2.
- Steady-state throughput is one instruction per cycle while stall=0.

## Configuration
- FETCH_PERF_EN defined: two extra outputs, each 32-bit wrapping and reset to 0.
  - perf_fetched counts cycles where valid_o & ~stall.
  - perf_stall counts cycles where stall & state_q==RUN.
- FETCH_PERF_EN undefined: both ports and both counters are absent; the rest of the behaviour is identical.

## Structure
- Shared cpu_pkg holds:
  - the fetch state encoding (RUN, HALT);
  - NOP_INS = 32'h0;
  - DEFAULT_RESET_PC.
- The counters live in one sub-module, fetch_perf_ctr, which is instantiated only under FETCH_PERF_EN.

## Test plan
- Reset release with stall/halt/jump_rst all 0:
  - imem_addr is 0,1,2,3 on cycles 0–3.
  - PC_o is 0x0,0x4,0x8 on cycles 1–3, with valid_o=1 from cycle 1.
- stall held 2 cycles while PC_o=0x8:
  - imem_en=0, and Ins_o/PC_o are held at 0x8's word.
  - PC_o=0xC on the first cycle after release.
- jump_rst with jump_target=0x43 while PC_o=0x10:
  - In that cycle imem_addr=0x10 and valid_o=0.
  - Then PC_o=0x40, followed by 0x44.
- halt while PC_o=0x14:
  - valid_o=0 and imem_en=0 for the whole time in HALT.
  - go pulse: imem_addr=0x5 one cycle later, PC_o=0x14 two cycles later.
- Same cycle jump_rst(0x80) + halt + stall: state stays RUN, and the next PC_o is 0x80.
- Async rst asserted mid-stream between clock edges:
  - valid_o, Ins_o and PC_o drop to 0 at once.
  - After release, fetch restarts at RESET_PC.
- With FETCH_PERF_EN defined, run the first and second scenarios: perf_fetched and perf_stall match the counts of qualifying cycles.
